dram_req_ctrl: RTL and testbench
================================

Name: dram_req_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port DRAM block model and is the only agent driving its write_enb/read_enb/address/data_in.
- Converts a valid/ready request stream into single-cycle memory strobes and returns read data on a valid/ready response channel.
- Periodically steals the port for a read-then-write-back refresh sweep over all addresses, so the block emulates DRAM refresh ordering.

Parameters:
- ADDR_W, 4, address width; memory depth is 2^ADDR_W.
- DATA_W, 8, data word width.
- REFRESH_PERIOD, 64, cycles between refresh requests; legal range is 8 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts the request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_W  read data.
- mem_write_enb  output  1  to memory write_enb.
- mem_read_enb  output  1  to memory read_enb.
- mem_address  output  ADDR_W  to memory address.
- mem_data_in  output  DATA_W  to memory data_in.
- mem_data_out  input  DATA_W  from memory data_out, which is registered and updates on the clock edge that samples read_enb.
- refresh_active  output  1  high in any refresh state.

Behaviour:
- Reset:
  - state = IDLE; all outputs 0; addr_q, wdata_q, rdata_q, ref_ptr, ref_cnt and ref_pending = 0.
  - Reset mid-operation abandons any request in flight: no write strobe is issued and no response is produced.
- States: IDLE, WR, RD, RD_CAP, RSP, REF_RD, REF_CAP, REF_WR.
- Memory-side outputs are Moore outputs, decoded from the state register and captured registers only.
- mem_write_enb and mem_read_enb are never high together.
- IDLE:
  - req_ready = !ref_pending.
  - If ref_pending: go to REF_RD and clear ref_pending. Refresh has priority over a waiting request.
  - Else if req_valid: capture req_addr and req_wdata. Go to WR if req_we, otherwise RD.
- WR:
  - Drives mem_write_enb=1, mem_address=addr_q, mem_data_in=wdata_q.
  - Next state: IDLE.
- RD:
  - Drives mem_read_enb=1, mem_address=addr_q.
  - Next state: RD_CAP.
- RD_CAP:
  - rdata_q <= mem_data_out.
  - Next state: RSP.
- RSP:
  - rsp_valid=1, rsp_rdata=rdata_q.
  - Holds until rsp_ready, then goes to IDLE. rsp_rdata is stable while rsp_valid && !rsp_ready.
- REF_RD:
  - Drives mem_read_enb=1, mem_address=ref_ptr.
  - Next state: REF_CAP.
- REF_CAP:
  - rdata_q <= mem_data_out.
  - Next state: REF_WR.
- REF_WR:
  - Drives mem_write_enb=1, mem_address=ref_ptr, mem_data_in=rdata_q.
  - ref_ptr increments, wrapping from 2^ADDR_W-1 to 0.
  - Next state: IDLE.
- rsp_rdata holds its last value outside RSP; only rsp_valid qualifies it.
- Latency (request handshake in cycle T):
  - Write: strobe in T+1; data is in memory after the T+1 edge.
  - Read: strobe in T+1, capture in T+2, rsp_valid in T+3.
  - Back-to-back: next req_ready no earlier than T+2 for writes and the cycle after the response handshake for reads.
- Refresh timer:
  - ref_cnt is free-running and is not stalled by traffic.
  - When ref_cnt == REFRESH_PERIOD-1: ref_cnt <= 0 and ref_pending <= 1.
  - Set wins over clear in the same cycle.
  - ref_pending is sticky and saturating: at most one refresh is owed, with no accumulation.
  - A refresh always completes once started; requests wait.
- Refresh data: the refresh write-back uses the value just read, so memory contents are unchanged by refresh.
- Simultaneous events: a request arriving in the same cycle ref_pending rises (IDLE, ref_pending already 1) is not accepted; req_ready = 0.

Test Plan:
- Reset, then write addr 3 = 0xA5, then read addr 3 -> mem_write_enb for 1 cycle at T+1; rsp_valid at T+3 with rsp_rdata = 0xA5.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and IDLE follows the cycle after rsp_ready=1.
- Idle for 64 cycles after reset -> refresh_active for 3 cycles, REF_RD/REF_WR on addr 0, memory contents unchanged, ref_ptr = 1. After 16 refreshes ref_ptr wraps to 0.
- req_valid held high continuously with writes to rising addresses -> a refresh is inserted every 64 cycles, req_ready = 0 while ref_pending, and no request is lost or duplicated.
- Assert reset while in RD and while in REF_WR -> all outputs return to 0 immediately; the following read of a pre-written addr returns the correct data.
- Random write/read mix for 10k cycles against a reference array -> every rsp_rdata matches, and mem_write_enb && mem_read_enb is never 1.

Source files
------------

// File: rtl/dram_req_ctrl.sv
// Request-side controller for the single-port DRAM block model: turns a valid/ready
// request stream into single-cycle memory strobes and interleaves periodic refresh sweeps.
module dram_req_ctrl #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned REFRESH_PERIOD = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_write_enb,
    output logic              mem_read_enb,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              refresh_active
);

    localparam int unsigned CNT_W = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD, RD_CAP, RSP, REF_RD, REF_CAP, REF_WR
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  ref_ptr_q, ref_ptr_d;
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               ref_pending_q, ref_pending_d;

    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               mem_write_enb_q, mem_write_enb_d;
    logic               mem_read_enb_q, mem_read_enb_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [DATA_W-1:0]  mem_data_in_q, mem_data_in_d;
    logic               refresh_active_q, refresh_active_d;

    // Next state plus outputs precomputed from the next state so every output is a flop.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ref_ptr_d     = ref_ptr_q;
        ref_pending_d = ref_pending_q;
        ref_cnt_d     = (ref_cnt_q == CNT_LAST) ? '0 : ref_cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (ref_pending_q) begin
                    state_d       = REF_RD;
                    ref_pending_d = 1'b0;
                end else if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = mem_data_out;
                state_d = RSP;
            end
            RSP:     if (rsp_ready) state_d = IDLE;
            REF_RD:  state_d = REF_CAP;
            REF_CAP: begin
                rdata_d = mem_data_out;
                state_d = REF_WR;
            end
            REF_WR: begin
                ref_ptr_d = ref_ptr_q + ADDR_W'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new refresh request wins over the clear taken in IDLE.
        if (ref_cnt_q == CNT_LAST) ref_pending_d = 1'b1;

        req_ready_d      = (state_d == IDLE) && !ref_pending_d;
        rsp_valid_d      = (state_d == RSP);
        rsp_rdata_d      = (state_d == RSP) ? rdata_d : rsp_rdata_q;
        mem_write_enb_d  = (state_d == WR) || (state_d == REF_WR);
        mem_read_enb_d   = (state_d == RD) || (state_d == REF_RD);
        refresh_active_d = (state_d == REF_RD) || (state_d == REF_CAP) || (state_d == REF_WR);

        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        if ((state_d == WR) || (state_d == RD)) mem_address_d = addr_d;
        if ((state_d == REF_RD) || (state_d == REF_WR)) mem_address_d = ref_ptr_d;
        if (state_d == WR) mem_data_in_d = wdata_d;
        if (state_d == REF_WR) mem_data_in_d = rdata_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            ref_ptr_q        <= '0;
            ref_cnt_q        <= '0;
            ref_pending_q    <= 1'b0;
            req_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            mem_write_enb_q  <= 1'b0;
            mem_read_enb_q   <= 1'b0;
            mem_address_q    <= '0;
            mem_data_in_q    <= '0;
            refresh_active_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            ref_ptr_q        <= ref_ptr_d;
            ref_cnt_q        <= ref_cnt_d;
            ref_pending_q    <= ref_pending_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            mem_write_enb_q  <= mem_write_enb_d;
            mem_read_enb_q   <= mem_read_enb_d;
            mem_address_q    <= mem_address_d;
            mem_data_in_q    <= mem_data_in_d;
            refresh_active_q <= refresh_active_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_write_enb  = mem_write_enb_q;
    assign mem_read_enb   = mem_read_enb_q;
    assign mem_address    = mem_address_q;
    assign mem_data_in    = mem_data_in_q;
    assign refresh_active = refresh_active_q;

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Directed and table-driven bench for dram_req_ctrl with a registered single-port memory model.
module tb_dram_req_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       mem_write_enb;
    logic       mem_read_enb;
    logic [3:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       refresh_active;

    dram_req_ctrl #(.ADDR_W(4), .DATA_W(8), .REFRESH_PERIOD(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_write_enb(mem_write_enb), .mem_read_enb(mem_read_enb),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .refresh_active(refresh_active)
    );

    always #5 clk = ~clk;

    // Memory model: registered read port, preloaded with 0x30+i.
    logic       preload = 1'b1;
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h30 + i);
        end else begin
            if (mem_write_enb) mem[mem_address] <= mem_data_in;
            if (mem_read_enb) mem_data_out <= mem[mem_address];
        end
    end

    // Monitors
    logic       mon_clr = 1'b0;
    bit         both_seen;
    bit         ra_prev;
    int         wr_cnt;
    int         cyc;
    logic [3:0] ref_addrs [$];
    int         ref_starts [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_write_enb && mem_read_enb) both_seen <= 1'b1;
        ra_prev <= refresh_active;
        if (mon_clr) begin
            ref_addrs.delete();
            ref_starts.delete();
            wr_cnt <= 0;
        end else begin
            if (mem_write_enb && refresh_active) ref_addrs.push_back(mem_address);
            if (mem_write_enb && !refresh_active) wr_cnt <= wr_cnt + 1;
            if (refresh_active && !ra_prev) ref_starts.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({req_ready, rsp_valid, rsp_rdata, mem_write_enb, mem_read_enb,
                    mem_address, mem_data_in, refresh_active});
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One request through the handshake; reads return the response data.
    task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d,
                          input bit bp, output logic [7:0] rd);
        int n = 0;
        rd = 'x;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin tick(); n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            tick();
            req_valid = 1'b0;
            if (we) begin
                ref_mem[a] = d;
            end else begin
                n = 0;
                while (!rsp_valid && n < 20) begin tick(); n++; end
                if (!rsp_valid) begin
                    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
                end else begin
                    n = 0;
                    while (bp && $urandom_range(0, 2) == 0 && n < 8) begin
                        rsp_ready = 1'b0; tick(); n++;
                    end
                    rsp_ready = 1'b1;
                    rd = rsp_rdata;
                    tick();
                end
            end
        end
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t       tbl [12];
        logic [7:0] rd;
        int         n;
        int         idx;
        bit         hs;
        bit         flag;

        tbl[0]  = '{1'b1, 4'd0,  8'h00, 8'h00};
        tbl[1]  = '{1'b1, 4'd15, 8'hFF, 8'h00};
        tbl[2]  = '{1'b1, 4'd7,  8'h5A, 8'h00};
        tbl[3]  = '{1'b1, 4'd8,  8'hC3, 8'h00};
        tbl[4]  = '{1'b0, 4'd0,  8'h00, 8'h00};
        tbl[5]  = '{1'b0, 4'd15, 8'h00, 8'hFF};
        tbl[6]  = '{1'b0, 4'd7,  8'h00, 8'h5A};
        tbl[7]  = '{1'b0, 4'd8,  8'h00, 8'hC3};
        tbl[8]  = '{1'b0, 4'd3,  8'h00, 8'hA5};
        tbl[9]  = '{1'b1, 4'd7,  8'h3C, 8'h00};
        tbl[10] = '{1'b0, 4'd7,  8'h00, 8'h3C};
        tbl[11] = '{1'b0, 4'd1,  8'h00, 8'h31};
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(8'h30 + i);

        // Reset state
        tick();
        chk("reset_outputs", outs_vec(), 32'd0);
        tick();
        preload = 1'b0;
        reset = 1'b0;

        // Write addr 3 = A5 with exact latency
        req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin tick(); n++; end
        chk("wr_ready_seen", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("wr_t1_strobe", 32'({mem_write_enb, mem_read_enb, mem_address, mem_data_in, req_ready}),
            32'({1'b1, 1'b0, 4'd3, 8'hA5, 1'b0}));
        tick();
        chk("wr_t2_idle", 32'({mem_write_enb, req_ready}), 32'({1'b0, 1'b1}));
        chk("wr_mem_content", 32'(mem[3]), 32'h A5);
        ref_mem[3] = 8'hA5;

        // Read addr 3 with exact latency and 5 cycles of backpressure
        req_we = 1'b0; req_addr = 4'd3; req_valid = 1'b1; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("rd_t1_strobe", 32'({mem_read_enb, mem_write_enb, mem_address, rsp_valid}),
            32'({1'b1, 1'b0, 4'd3, 1'b0}));
        tick();
        chk("rd_t2_capture", 32'({mem_read_enb, rsp_valid}), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold", 32'({rsp_valid, rsp_rdata, req_ready}), 32'({1'b1, 8'hA5, 1'b0}));
            tick();
        end
        rsp_ready = 1'b1;
        chk("rd_hold_last", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, 8'hA5}));
        tick();
        chk("rd_after_hs", 32'({rsp_valid, req_ready, rsp_rdata}), 32'({1'b0, 1'b1, 8'hA5}));

        // Table-driven directed vectors
        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, rd);
            if (!tbl[i].we) chk($sformatf("tbl_rd_%0d", i), 32'(rd), 32'(tbl[i].exp));
        end

        // Refresh after 64 idle cycles, then sweep wrap
        do_reset();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        for (int i = 0; i < 62; i++) tick();
        chk("ref_pre_idle", 32'({req_ready, refresh_active}), 32'({1'b1, 1'b0}));
        tick();
        chk("ref_pending_blocks", 32'({req_ready, refresh_active, mem_read_enb}), 32'd0);
        tick();
        chk("ref_rd", 32'({refresh_active, mem_read_enb, mem_write_enb, mem_address}),
            32'({1'b1, 1'b1, 1'b0, 4'd0}));
        tick();
        chk("ref_cap", 32'({refresh_active, mem_read_enb, mem_write_enb}), 32'({1'b1, 1'b0, 1'b0}));
        tick();
        chk("ref_wr", 32'({refresh_active, mem_write_enb, mem_address, mem_data_in}),
            32'({1'b1, 1'b1, 4'd0, ref_mem[0]}));
        tick();
        chk("ref_done", 32'({refresh_active, req_ready}), 32'({1'b0, 1'b1}));
        n = 0;
        while (ref_addrs.size() < 17 && n < 1200) begin tick(); n++; end
        chk("ref_sweep_count", 32'(ref_addrs.size()), 32'd17);
        flag = 1'b0;
        for (int i = 0; i < ref_addrs.size(); i++)
            if (ref_addrs[i] !== 4'(i % 16)) flag = 1'b1;
        chk("ref_sweep_order", 32'(flag), 32'd0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ref_unchanged_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

        // Reset while in REF_WR, then read back pre-written data
        n = 0;
        while (!(mem_write_enb && refresh_active) && n < 200) begin tick(); n++; end
        chk("ref_wr_reached", 32'(mem_write_enb && refresh_active), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_in_ref_wr", outs_vec(), 32'd0);
        tick();
        reset = 1'b0;
        do_req(1'b0, 4'd3, 8'h00, 1'b0, rd);
        chk("rd_after_ref_reset", 32'(rd), 32'hA5);

        // Reset while in RD abandons the read
        req_we = 1'b0; req_addr = 4'd5; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        chk("rd_state_reached", 32'(mem_read_enb && !refresh_active), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_in_rd", outs_vec(), 32'd0);
        tick();
        reset = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) flag = 1'b1;
            tick();
        end
        chk("no_rsp_after_reset", 32'(flag), 32'd0);
        do_req(1'b0, 4'd5, 8'h00, 1'b0, rd);
        chk("rd_after_rd_reset", 32'(rd), 32'h35);

        // Continuous writes with refreshes interleaved
        do_reset();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        idx = 0; n = 0;
        req_we = 1'b1; req_valid = 1'b1;
        req_addr = 4'(idx % 16); req_wdata = 8'(idx * 7 + 1);
        while (idx < 150 && n < 1000) begin
            hs = req_ready;
            tick();
            n++;
            if (hs) begin
                ref_mem[req_addr] = req_wdata;
                idx++;
                req_addr = 4'(idx % 16); req_wdata = 8'(idx * 7 + 1);
            end
        end
        req_valid = 1'b0;
        tick();
        tick();
        chk("stream_accepted", 32'(idx), 32'd150);
        chk("stream_strobes", 32'(wr_cnt), 32'd150);
        chk("stream_refreshes", 32'(ref_starts.size() >= 4), 32'd1);
        flag = 1'b0;
        for (int i = 1; i < ref_starts.size(); i++)
            if (ref_starts[i] - ref_starts[i-1] < 63 || ref_starts[i] - ref_starts[i-1] > 65) flag = 1'b1;
        chk("stream_ref_spacing", 32'(flag), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) flag = 1'b1;
        chk("stream_mem_content", 32'(flag), 32'd0);

        // Random mix against the reference array
        n = cyc;
        while (cyc - n < 10000) begin
            logic       we;
            logic [3:0] a;
            logic [7:0] d;
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            do_req(we, a, d, 1'b1, rd);
            if (!we) chk("rand_rd", 32'(rd), 32'(ref_mem[a]));
        end
        chk("no_dual_strobe", 32'(both_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
